// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: op encodings,
// FSM state type and default operand width.
package mul_seq_pkg;

    localparam int MUL_W_DEFAULT = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul_pg_adder.sv
// W-bit propagate/generate ripple adder with carry-out. approx_lo turns the low
// APPROX_BITS positions into carry-free OR cells (a|b) with no carry into the exact part.
module mul_pg_adder #(
    parameter int W           = 32,
    parameter int APPROX_BITS = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         approx_lo,
    output logic [W:0]   sum_o
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] s;
    logic [W:0]   c;

    always_comb begin
        p = a_i ^ b_i;
        g = a_i & b_i;
        s = '0;
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (approx_lo && (i < APPROX_BITS)) begin
                s[i]   = p[i] | g[i];
                c[i+1] = 1'b0;
            end else begin
                s[i]   = p[i] ^ c[i];
                c[i+1] = g[i] | (p[i] & c[i]);
            end
        end
    end

    assign sum_o = {c[W], s};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU with kill.
// Optional approximate low adder bits when MUL_SEQ_APPROX_EN is defined (adds port approx).
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W           = MUL_W_DEFAULT,
    parameter int APPROX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MUL_SEQ_APPROX_EN
    input  logic         approx,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    input  logic         kill,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         busy
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mul_state_e     state_q;
    logic [1:0]     op_q;
    logic           neg_q;
    logic           approx_q;
    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q;
    logic [W:0]     acc_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   result_q;

    logic           approx_in;
    logic           rs1_signed;
    logic           rs2_signed;
    logic           rs1_neg;
    logic           rs2_neg;
    logic [W-1:0]   rs1_abs;
    logic [W-1:0]   rs2_abs;
    logic [W:0]     add_sum;
    logic [W:0]     calc_sum;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;

`ifdef MUL_SEQ_APPROX_EN
    assign approx_in = approx;
`else
    assign approx_in = 1'b0;
`endif

    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign rs1_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    assign rs2_signed = (op == MUL_OP_MULH);
    assign rs1_neg    = rs1_signed & rs1[W-1];
    assign rs2_neg    = rs2_signed & rs2[W-1];
    assign rs1_abs    = rs1_neg ? (~rs1 + 1'b1) : rs1;
    assign rs2_abs    = rs2_neg ? (~rs2 + 1'b1) : rs2;

    mul_pg_adder #(
        .W           (W),
        .APPROX_BITS (APPROX_BITS)
    ) u_adder (
        .a_i       (acc_q[W-1:0]),
        .b_i       (mcand_q),
        .approx_lo (approx_q),
        .sum_o     (add_sum)
    );

    // acc_q[W] is always 0 after the right shift, so acc_q equals {0, acc[W-1:0]}.
    assign calc_sum = mplier_q[0] ? add_sum : acc_q;
    assign prod     = {acc_q[W-1:0], mplier_q};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            approx_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (kill) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        approx_q <= approx_in;
                        neg_q    <= rs1_neg ^ rs2_neg;
                        mcand_q  <= rs1_abs;
                        mplier_q <= rs2_abs;
                        acc_q    <= '0;
                        cnt_q    <= CNT_INIT;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q    <= {1'b0, calc_sum[W:1]};
                    mplier_q <= {calc_sum[0], mplier_q[W-1:1]};
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_q <= (op_q == MUL_OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner ops, backpressure, kill,
// async reset and a randomized sweep against a 2W-bit arithmetic reference.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         kill = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] result;
`ifdef MUL_SEQ_APPROX_EN
  logic         approx = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  mul_seq_ctrl #(.W(W), .APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MUL_SEQ_APPROX_EN
    .approx    (approx),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: extend each operand to 2W bits by its signedness and multiply.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] a2;
    logic [2*W-1:0] b2;
    logic [2*W-1:0] p;
    a2 = (o == 2'b01 || o == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    b2 = (o == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = a2 * b2;
    return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op; cycle 0 is the accept cycle, so out_valid is expected in cycle W+2.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ap, input logic [W-1:0] expv, input int bp,
                        input bit chk_lat, input int kill_at);
    int cyc;
    int guard;
    bit saw;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_req", in_ready, 1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
`ifdef MUL_SEQ_APPROX_EN
    approx = ap;
`else
    if (ap) check("approx_unsupported", 1, 0);
`endif
    if (kill_at == 0) exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
    op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
`ifdef MUL_SEQ_APPROX_EN
    approx = 1'($urandom);
`endif
    cyc = 1;
    if (kill_at > 0) begin
      while (cyc < kill_at) begin
        @(negedge clk);
        cyc++;
      end
      check("busy_before_kill", busy, 1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_in_ready", in_ready, 1);
      check("kill_busy", busy, 0);
      saw = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) saw = 1'b1;
      end
      check("kill_no_out_valid", saw, 0);
      return;
    end
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("out_valid_seen", out_valid, 1);
    if (chk_lat) check("latency_cycles", cyc, W + 2);
    held = result;
    for (int i = 0; i < bp; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_result", result, held);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("result", result, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready, 1);
    check("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 0, 1'b1, 0);
    run_op(2'b00, 32'h7,         32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 0, 1'b1, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 5, 1'b1, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 0, 1'b1, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 0, 1'b1, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 0);
    run_op(2'b00, 32'h0,         32'h1234_5678, 1'b0, 32'h0,         0, 1'b1, 0);

    // kill alongside a request in IDLE: nothing is accepted
    @(negedge clk);
    op = 2'b00; rs1 = 32'd2; rs2 = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("idle_kill_busy", busy, 0);
    check("idle_kill_in_ready", in_ready, 1);

    run_op(2'b00, 32'd5, 32'd9, 1'b0, 32'd0, 0, 1'b0, 10);
    run_op(2'b00, 32'd6, 32'd7, 1'b0, 32'd42, 0, 1'b1, 0);

    // asynchronous reset in the middle of CALC, checked between clock edges
    @(negedge clk);
    op = 2'b11; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef MUL_SEQ_APPROX_EN
    run_op(2'b00, 32'd3, 32'd3, 1'b1, 32'd7, 0, 1'b1, 0);
    run_op(2'b00, 32'd3, 32'd3, 1'b0, 32'd9, 0, 1'b1, 0);
`endif

    for (int n = 0; n < 1000; n++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      run_op(o, a, b, 1'b0, ref_mul(o, a, b), $urandom_range(0, 3), 1'b1, 0);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
